// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [4:0] OpPassA = 5'b00000;
    localparam logic [4:0] OpAdd   = 5'b00001;
    localparam logic [4:0] OpSub   = 5'b00010;
    localparam logic [4:0] OpIncB  = 5'b00011;
    localparam logic [4:0] OpDecB  = 5'b00100;
    localparam logic [4:0] OpAnd   = 5'b00101;
    localparam logic [4:0] OpOr    = 5'b00110;
    localparam logic [4:0] OpXor   = 5'b00111;
    localparam logic [4:0] OpNotA  = 5'b01000;
    localparam logic [4:0] OpSll   = 5'b01001;
    localparam logic [4:0] OpSrl   = 5'b01010;
    localparam logic [4:0] OpLtu   = 5'b01011;
    localparam logic [4:0] OpMul   = 5'b01100;
    localparam logic [4:0] OpDiv   = 5'b01101;
    localparam logic [4:0] OpRem   = 5'b01110;
    localparam logic [4:0] OpPassB = 5'b01111;
    localparam logic [4:0] OpLtuB  = 5'b10000;
    localparam logic [4:0] OpLeu   = 5'b10001;
    localparam logic [4:0] OpGtu   = 5'b10010;
    localparam logic [4:0] OpGeu   = 5'b10011;
    localparam logic [4:0] OpLts   = 5'b10100;
    localparam logic [4:0] OpSra   = 5'b10101;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/alu_iterdiv.sv
// Iterative unsigned restoring divider: one quotient bit per step_i, WIDTH steps per division.
module alu_iterdiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH:0]   shifted, diff;

    // A zero divisor never borrows, so quotient fills with ones and remainder becomes dividend.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (diff[WIDTH]) begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    // Post-step values, so the final result is visible during the last step cycle.
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops, shift-add multiply and
// iterative divide, result held in DONE until accepted.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [4:0]       cu_aluOp,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluOut,
    output logic             zero,
    output logic             negative,
    output logic             div_by_zero
);

    localparam logic [SHW:0] LastIter = (SHW+1)'(WIDTH - 1);

    alu_state_e       state_q;
    logic [SHW:0]     iter_q;
    logic [4:0]       op_q;
    logic             dvs_zero_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             out_valid_q, zero_q, neg_q, dbz_q;

    logic [WIDTH-1:0] sc_result, fin_result, quotient, remainder;
    logic             fin_now, fin_dbz, div_start, div_step, accept;

    assign accept    = (state_q == StIdle) && in_valid;
    assign div_start = accept && is_div_op(cu_aluOp);
    assign div_step  = (state_q == StDiv);

    alu_iterdiv #(
        .WIDTH (WIDTH)
    ) u_iterdiv (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .step_i      (div_step),
        .dividend_i  (data1),
        .divisor_i   (data2),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_comb begin
        sc_result = '0;
        case (cu_aluOp)
            OpPassA: sc_result = data1;
            OpAdd:   sc_result = data1 + data2;
            OpSub:   sc_result = data1 - data2;
            OpIncB:  sc_result = data2 + WIDTH'(1);
            OpDecB:  sc_result = data2 - WIDTH'(1);
            OpAnd:   sc_result = data1 & data2;
            OpOr:    sc_result = data1 | data2;
            OpXor:   sc_result = data1 ^ data2;
            OpNotA:  sc_result = ~data1;
            OpSll:   sc_result = data1 << shamt;
            OpSrl:   sc_result = data1 >> shamt;
            OpSra:   sc_result = $signed(data1) >>> shamt;
            OpLtu,
            OpLtuB:  sc_result = {{(WIDTH-1){1'b0}}, data1 < data2};
            OpLeu:   sc_result = {{(WIDTH-1){1'b0}}, data1 <= data2};
            OpGtu:   sc_result = {{(WIDTH-1){1'b0}}, data1 > data2};
            OpGeu:   sc_result = {{(WIDTH-1){1'b0}}, data1 >= data2};
            OpLts:   sc_result = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
            OpPassB: sc_result = data2;
            default: sc_result = '0;
        endcase
    end

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        fin_now    = 1'b0;
        fin_dbz    = 1'b0;
        fin_result = sc_result;
        case (state_q)
            StIdle: fin_now = accept && (cu_aluOp != OpMul) && !is_div_op(cu_aluOp);
            StMul: begin
                fin_now    = (iter_q == LastIter);
                fin_result = acc_d;
            end
            StDiv: begin
                fin_now    = (iter_q == LastIter);
                fin_dbz    = dvs_zero_q;
                fin_result = (op_q == OpDiv) ? quotient : remainder;
            end
            default: fin_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            iter_q      <= '0;
            op_q        <= '0;
            dvs_zero_q  <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q       <= cu_aluOp;
                        iter_q     <= '0;
                        dvs_zero_q <= (data2 == '0);
                        if (cu_aluOp == OpMul) begin
                            mcand_q  <= data1;
                            mplier_q <= data2;
                            acc_q    <= '0;
                            state_q  <= StMul;
                        end else if (is_div_op(cu_aluOp)) begin
                            state_q <= StDiv;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StMul: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    iter_q   <= iter_q + (SHW+1)'(1);
                    if (iter_q == LastIter) begin
                        iter_q  <= '0;
                        state_q <= StDone;
                    end
                end
                StDiv: begin
                    iter_q <= iter_q + (SHW+1)'(1);
                    if (iter_q == LastIter) begin
                        iter_q  <= '0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (fin_now) begin
                alu_out_q   <= fin_result;
                zero_q      <= (fin_result == '0);
                neg_q       <= fin_result[WIDTH-1];
                dbz_q       <= fin_dbz;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign aluOut      = alu_out_q;
    assign zero        = zero_q;
    assign negative    = neg_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 data1  input  WIDTH  operand A.
REQ-008 data2  input  WIDTH  operand B.
REQ-009 cu_aluOp  input  5  operation select, encoding per REQ-015.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 aluOut  output  WIDTH  result.
REQ-014 zero, negative, div_by_zero  output  1 each  flags qualified by out_valid.

Function
REQ-015 Opcodes SHALL be: 00000 pass A; 00001 A+B; 00010 A-B; 00011 B+1; 00100 B-1; 00101 AND; 00110 OR; 00111 XOR; 01000 NOT A; 01001 A<<shamt; 01010 A>>shamt (logical); 01011/10000 A<B; 10001 A<=B; 10010 A>B; 10011 A>=B (unsigned); 01100 MUL; 01101 DIV; 01110 REM; 01111 pass B; 10100 A<B signed; 10101 A>>>shamt (arithmetic); all others result 0.
REQ-016 Add/sub/inc/dec SHALL wrap modulo 2^WIDTH; MUL SHALL return low WIDTH bits of unsigned product; DIV/REM unsigned; compares return 1 or 0 zero-extended.
REQ-017 FSM states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Handshake SHALL occur when in_valid and in_ready are high at a rising edge (cycle 0); operands, opcode, shamt captured then; inputs ignored otherwise.
REQ-019 Single-cycle opcodes SHALL go IDLE->DONE, out_valid high from cycle 1.
REQ-020 MUL SHALL go IDLE->MUL, perform one shift-add step per cycle for WIDTH cycles, then DONE; out_valid high from cycle WIDTH+1.
REQ-021 DIV/REM SHALL go IDLE->DIV, one restoring-division step per cycle for WIDTH cycles, then DONE; out_valid high from cycle WIDTH+1.
REQ-022 Divide by zero SHALL still take WIDTH+1 cycles; DIV result all-ones, REM result data1, div_by_zero=1; div_by_zero=0 for all other operations.
REQ-023 In DONE, aluOut and flags SHALL hold stable until out_ready=1; DONE->IDLE on that edge.
REQ-024 out_valid and out_ready high in same cycle SHALL complete transfer; next handshake earliest the following cycle (no back-to-back bypass).
REQ-025 zero = (aluOut==0); negative = aluOut[WIDTH-1]; both from registered result.
REQ-026 Shift amounts >= WIDTH cannot occur by width; shamt=0 returns A unchanged.
REQ-027 in_valid during MUL/DIV/DONE SHALL not disturb the operation in flight.

Reset
REQ-028 rst SHALL force IDLE, in_ready=1 after reset release edge, out_valid=0, aluOut=0, zero=0, negative=0, div_by_zero=0, iteration counter=0.
REQ-029 rst asserted mid-MUL/DIV or in DONE SHALL discard the operation with no out_valid pulse; rst has priority over a simultaneous handshake.

Structure
REQ-030 Opcode constants and FSM state type SHALL live in shared package alu_pkg.
REQ-031 Iterative restoring divider SHALL be sub-module alu_iterdiv (start, WIDTH-step, quotient and remainder outputs); multiplier and single-cycle ops stay in alu_multicycle.
REQ-032 Iteration counter SHALL be SHW+1 bits wide.

Verification (WIDTH=32)
REQ-033 A=7,B=5 op 00001, out_ready=1 -> out_valid in cycle 1, aluOut=12, zero=0.
REQ-034 A=0xFFFF_FFFF,B=1 op 00001 -> aluOut=0, zero=1; op 10101 A=0x8000_0000 shamt=4 -> 0xF800_0000, negative=1.
REQ-035 A=1000,B=3000 op 01100 -> out_valid first in cycle 33, aluOut=3,000,000; in_ready=0 cycles 1..33.
REQ-036 A=100,B=7 op 01101 -> 14; op 01110 -> 2; A=5,B=0 op 01101 -> 0xFFFF_FFFF, div_by_zero=1; op 01110 -> 5.
REQ-037 Single op with out_ready=0 for 10 cycles -> aluOut stable, in_ready=0 throughout, completes on first out_ready=1.
REQ-038 rst at cycle 10 of DIV -> IDLE next cycle, out_valid never asserted, new op accepted after rst release.
